// File: rtl/knn_ctrl_pkg.sv
// Shared kNN types and defaults.
// Imported by the controller, the vote matcher and the datapath.
package knn_ctrl_pkg;

    localparam int KNN_K_DEFAULT       = 10;
    localparam int KNN_LABEL_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_VOTE  = 3'd4,
        ST_DONE  = 3'd5
    } knn_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/knn_vote_match.sv
// Counts filled neighbour slots whose label equals slot j's label.
// K comparators feeding a popcount; purely combinational.
module knn_vote_match
    import knn_ctrl_pkg::*;
#(
    parameter int K       = KNN_K_DEFAULT,
    parameter int LABEL_W = KNN_LABEL_W_DEFAULT,
    parameter int CW      = clog2(K + 1),
    parameter int JW      = (K > 1) ? clog2(K) : 1
) (
    input  logic [LABEL_W*K-1:0] labels,
    input  logic [JW-1:0]        j,
    input  logic [CW-1:0]        filled,
    output logic [LABEL_W-1:0]   sel_label,
    output logic [CW-1:0]        count
);

    always_comb begin
        sel_label = labels[int'(j)*LABEL_W +: LABEL_W];
        count     = '0;
        for (int i = 0; i < K; i++) begin
            if ((CW'(i) < filled) &&
                (labels[i*LABEL_W +: LABEL_W] == sel_label)) begin
                count = count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/knn_ctrl.sv
// kNN sequencer: clear chain, stream N points, majority vote over K.
// Define KNN_CTRL_CYCLE_CNT_EN to add the `cycles` latency counter.
module knn_ctrl
    import knn_ctrl_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LABEL_W      = KNN_LABEL_W_DEFAULT,
    parameter int K_NEIGHBOURS = KNN_K_DEFAULT,
    parameter int ADDR_W       = 10,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W:0]              n_points,
    output logic                         mem_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [LABEL_W-1:0]           mem_label,
    output logic                         dp_valid,
    output logic [LABEL_W-1:0]           dp_label,
    output logic                         dp_clear,
    input  logic [LABEL_W*K_NEIGHBOURS-1:0] nb_labels,
    output logic                         busy,
    output logic                         done,
    output logic                         empty,
    output logic [LABEL_W-1:0]           result_label
`ifdef KNN_CTRL_CYCLE_CNT_EN
    ,
    output logic [2*DATA_W-1:0]          cycles
`endif
);

    localparam int NW   = ADDR_W + 1;
    localparam int CW   = clog2(K_NEIGHBOURS + 1);
    localparam int JW   = (K_NEIGHBOURS > 1) ? clog2(K_NEIGHBOURS) : 1;
    localparam int SMAX = (K_NEIGHBOURS > DRAIN_CYCLES) ? K_NEIGHBOURS
                                                        : DRAIN_CYCLES;
    localparam int SW   = clog2(SMAX + 1);

    if (K_NEIGHBOURS < 1 || DATA_W < 2) begin : g_bad_params
        $error("knn_ctrl: K_NEIGHBOURS must be >= 1 and DATA_W >= 2");
    end

    knn_state_e         state, state_nxt;
    logic [NW-1:0]      n_reg;
    logic [NW-1:0]      addr_cnt;
    logic [SW-1:0]      step_cnt;
    logic [CW-1:0]      best_cnt;
    logic [LABEL_W-1:0] best_label;
    logic [CW-1:0]      filled;
    logic [JW-1:0]      j;
    logic [LABEL_W-1:0] sel_label;
    logic [CW-1:0]      count;
    logic               upd;

    assign mem_en   = (state == ST_FETCH);
    assign mem_addr = mem_en ? addr_cnt[ADDR_W-1:0] : '0;
    assign dp_clear = (state == ST_CLEAR);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    // Memory data arrives with dp_valid; gating keeps it quiet otherwise.
    assign dp_label = dp_valid ? mem_label : '0;

    assign j = JW'(step_cnt);

    always_comb begin
        if (int'(n_reg) >= K_NEIGHBOURS) filled = CW'(K_NEIGHBOURS);
        else                             filled = CW'(n_reg);
    end

    knn_vote_match #(
        .K       (K_NEIGHBOURS),
        .LABEL_W (LABEL_W),
        .CW      (CW),
        .JW      (JW)
    ) u_match (
        .labels    (nb_labels),
        .j         (j),
        .filled    (filled),
        .sel_label (sel_label),
        .count     (count)
    );

    // Strict compare: equal counts keep the nearer neighbour.
    assign upd = (CW'(j) < filled) && (count > best_cnt);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = (n_reg == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: if (addr_cnt == n_reg - NW'(1)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (step_cnt == SW'(DRAIN_CYCLES - 1))
                          state_nxt = ST_VOTE;
            ST_VOTE:  if (step_cnt == SW'(K_NEIGHBOURS - 1))
                          state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            n_reg        <= '0;
            addr_cnt     <= '0;
            step_cnt     <= '0;
            best_cnt     <= '0;
            best_label   <= '0;
            result_label <= '0;
            empty        <= 1'b0;
            dp_valid     <= 1'b0;
        end else begin
            state    <= state_nxt;
            dp_valid <= mem_en;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_reg        <= n_points;
                        empty        <= 1'b0;
                        result_label <= '0;
                    end
                end
                ST_CLEAR: begin
                    addr_cnt   <= '0;
                    step_cnt   <= '0;
                    best_cnt   <= '0;
                    best_label <= '0;
                    if (n_reg == '0) empty <= 1'b1;
                end
                ST_FETCH: addr_cnt <= addr_cnt + NW'(1);
                ST_DRAIN: begin
                    if (state_nxt == ST_VOTE) step_cnt <= '0;
                    else                      step_cnt <= step_cnt + SW'(1);
                end
                ST_VOTE: begin
                    step_cnt <= step_cnt + SW'(1);
                    if (upd) begin
                        best_cnt   <= count;
                        best_label <= sel_label;
                    end
                    if (state_nxt == ST_DONE)
                        result_label <= upd ? sel_label : best_label;
                end
                default: ;
            endcase
        end
    end

`ifdef KNN_CTRL_CYCLE_CNT_EN
    // Value seen during a busy cycle counts that cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= '0;
        end else if (state == ST_IDLE && start) begin
            cycles <= (2*DATA_W)'(1);
        end else if (state != ST_IDLE && state != ST_DONE) begin
            cycles <= cycles + (2*DATA_W)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_knn_ctrl.sv
// Scoreboard bench for knn_ctrl with K=4, DRAIN_CYCLES=2.
// Driver queues expected addresses/results; monitor pops and compares.
module tb_knn_ctrl;

    localparam int K  = 4;
    localparam int LW = 8;
    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        logic [LW-1:0] lab;
        bit            emp;
        int            lat;
        int            t0;
    } res_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW:0]     n_points = '0;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic [LW-1:0]   mem_label = '0;
    logic            dp_valid;
    logic [LW-1:0]   dp_label;
    logic            dp_clear;
    logic [LW*K-1:0] nb_labels = '0;
    logic            busy;
    logic            done;
    logic            empty;
    logic [LW-1:0]   result_label;
`ifdef KNN_CTRL_CYCLE_CNT_EN
    logic [2*DW-1:0] cycles;
`endif

    logic [LW-1:0] mem_lab [1024];
    int            addr_q[$];
    res_t          res_q[$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    bit            pend_ok = 1'b0;
    int            pend_addr = 0;
    int            clear_cnt = 0;
    bit            prev_done = 1'b0;
    int            last_lat = 0;

    knn_ctrl #(
        .DATA_W       (DW),
        .LABEL_W      (LW),
        .K_NEIGHBOURS (K),
        .ADDR_W       (AW),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n_points     (n_points),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_label    (mem_label),
        .dp_valid     (dp_valid),
        .dp_label     (dp_label),
        .dp_clear     (dp_clear),
        .nb_labels    (nb_labels),
        .busy         (busy),
        .done         (done),
        .empty        (empty),
        .result_label (result_label)
`ifdef KNN_CTRL_CYCLE_CNT_EN
        ,
        .cycles       (cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_label <= mem_lab[mem_addr];
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compares DUT activity against the queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("dp_valid_align", dp_valid, pend_ok);
                if (dp_valid && pend_ok) begin
                    if (addr_q.size() == 0) begin
                        fail("unexpected_dp_valid");
                    end else begin
                        check("mem_addr_order", pend_addr,
                              addr_q.pop_front());
                        check("dp_label", dp_label, mem_lab[pend_addr]);
                    end
                end
                pend_ok   = mem_en;
                pend_addr = mem_addr;
                if (dp_clear) begin
                    clear_cnt++;
                    check("clear_empty", empty, 0);
                    check("clear_result", result_label, 0);
                    check("clear_busy", busy, 1);
                end
                if (prev_done) begin
                    check("done_one_cycle", done, 0);
                    check("busy_after_done", busy, 0);
`ifdef KNN_CTRL_CYCLE_CNT_EN
                    check("cycles_hold", cycles, last_lat);
`endif
                end
                if (done) begin
                    if (res_q.size() == 0) begin
                        fail("unexpected_done");
                    end else begin
                        res_t r;
                        r = res_q.pop_front();
                        check("result_label", result_label, r.lab);
                        check("empty", empty, r.emp);
                        check("latency", cyc - r.t0, r.lat);
                        check("busy_at_done", busy, 1);
                        check("clear_pulses", clear_cnt, 1);
                        check("addr_all_seen", addr_q.size(), 0);
                        last_lat = r.lat;
`ifdef KNN_CTRL_CYCLE_CNT_EN
                        check("cycles", cycles, r.lat);
`endif
                    end
                    clear_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    task automatic load(input int n, input logic [LW-1:0] l0, l1, l2, l3);
        nb_labels = {l3, l2, l1, l0};
        n_points  = (AW+1)'(n);
        for (int i = 0; i < n; i++) addr_q.push_back(i);
    endtask

    // Called at a negedge with the DUT idle.
    task automatic run(input int n, input logic [LW-1:0] l0, l1, l2, l3,
                       input logic [LW-1:0] exp_lab, input bit hold,
                       input bit pulse_mid);
        res_t r;
        load(n, l0, l1, l2, l3);
        r.lab = exp_lab;
        r.emp = (n == 0);
        r.lat = (n == 0) ? 2 : 2 + n + 2 + K;
        r.t0  = cyc;
        res_q.push_back(r);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (pulse_mid) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int t = 0; t < 300 && !done; t++) @(negedge clk);
        if (!done) fail("done_timeout");
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [LW-1:0] seq1 [6];
        seq1 = '{8'd3, 8'd1, 8'd3, 8'd2, 8'd3, 8'd1};
        for (int i = 0; i < 1024; i++) mem_lab[i] = LW'(i * 7 + 1);
        for (int i = 0; i < 6; i++) mem_lab[i] = seq1[i];

        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dp_valid", dp_valid, 0);
        check("rst_dp_clear", dp_clear, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_empty", empty, 0);
        check("rst_result", result_label, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(6, 8'd3, 8'd1, 8'd3, 8'd2, 8'd3, 1'b0, 1'b0);
        run(4, 8'd5, 8'd2, 8'd2, 8'd5, 8'd5, 1'b0, 1'b0);
        run(4, 8'd7, 8'd4, 8'd1, 8'd9, 8'd7, 1'b0, 1'b0);
        run(2, 8'd6, 8'd6, 8'd9, 8'd9, 8'd6, 1'b0, 1'b0);
        run(3, 8'd2, 8'd8, 8'd8, 8'd2, 8'd8, 1'b0, 1'b0);
        run(0, 8'd4, 8'd4, 8'd4, 8'd4, 8'd0, 1'b0, 1'b0);
        run(6, 8'd3, 8'd1, 8'd3, 8'd2, 8'd3, 1'b1, 1'b0);
        run(5, 8'd4, 8'd4, 8'd8, 8'd8, 8'd4, 1'b0, 1'b1);
        check("idle_after_runs", busy, 0);

        // Abort mid-FETCH at address 3 of 6.
        load(6, 8'd3, 8'd1, 8'd3, 8'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 50 && !(mem_en && mem_addr == 3); t++)
            @(negedge clk);
        if (!(mem_en && mem_addr == 3)) fail("abort_addr_timeout");
        #1 rst = 1'b1;
        #1;
        check("abort_mem_en", mem_en, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_dp_valid", dp_valid, 0);
        check("abort_dp_label", dp_label, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_empty", empty, 0);
        check("abort_result", result_label, 0);
        addr_q.delete();
        pend_ok   = 1'b0;
        clear_cnt = 0;
        prev_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", busy, 0);
        run(6, 8'd3, 8'd1, 8'd3, 8'd2, 8'd3, 1'b0, 1'b0);

        check("addr_q_drained", addr_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
